// File: rtl/seq_pkg.sv
// Shared types and sizing helpers for the serial pattern detector.
package seq_pkg;

   typedef enum logic {
      FILL  = 1'b0,
      ARMED = 1'b1
   } state_e;

   // Width needed for a counter that must reach pat_w inclusive.
   function automatic int unsigned fill_cnt_w(input int unsigned pat_w);
      return $clog2(pat_w + 1);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a dominant synchronous clear.
module sat_counter #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] cnt
);

   localparam logic [W-1:0] CNT_MAX = '1;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != CNT_MAX)) begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/seq_pattern_detector.sv
// Serial pattern detector: loadable pattern, overlapping or non-overlapping
// detection, registered one-cycle match pulse and saturating match counter.
module seq_pattern_detector
   import seq_pkg::*;
#(
   parameter int unsigned           PAT_W       = 4,
   parameter int unsigned           CNT_W       = 8,
   parameter logic [PAT_W-1:0]      RST_PATTERN = PAT_W'(4'b1011)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             din_valid,
   input  logic             din,
   input  logic             cfg_load,
   input  logic [PAT_W-1:0] cfg_pattern,
   input  logic             cfg_overlap,
   input  logic             clear_cnt,
   output logic             match,
   output logic [CNT_W-1:0] match_cnt,
   output logic             armed
);

   localparam int unsigned FCW = fill_cnt_w(PAT_W);

   state_e           state, state_n;
   logic [PAT_W-1:0] hist, hist_n;
   logic [FCW-1:0]   fill_cnt, fill_n;
   logic [PAT_W-1:0] pattern;
   logic             overlap;

   logic [PAT_W-1:0] shifted_c;
   logic             compare_c;
   logic             last_fill_c;
   logic             hit_c;

   assign shifted_c   = {hist[PAT_W-2:0], din};
   assign compare_c   = (shifted_c == pattern);
   assign last_fill_c = (fill_cnt == FCW'(PAT_W - 1));

   // Next-state, history and hit decode.
   always_comb begin
      state_n = state;
      hist_n  = hist;
      fill_n  = fill_cnt;
      hit_c   = 1'b0;

      if (cfg_load) begin
         // A bit accepted alongside a reconfiguration is dropped.
         state_n = FILL;
         hist_n  = '0;
         fill_n  = '0;
      end else if (din_valid) begin
         case (state)
            FILL: begin
               hist_n = shifted_c;
               fill_n = fill_cnt + FCW'(1);
               if (last_fill_c) begin
                  state_n = ARMED;
                  hit_c   = compare_c;
               end
            end
            ARMED: begin
               hist_n = shifted_c;
               hit_c  = compare_c;
            end
            default: begin
               state_n = FILL;
               hist_n  = '0;
               fill_n  = '0;
            end
         endcase

         // Non-overlapping mode restarts collection after every hit.
         if (hit_c && !overlap) begin
            state_n = FILL;
            hist_n  = '0;
            fill_n  = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= FILL;
         hist     <= '0;
         fill_cnt <= '0;
         pattern  <= RST_PATTERN;
         overlap  <= 1'b1;
         match    <= 1'b0;
         armed    <= 1'b0;
      end else begin
         state    <= state_n;
         hist     <= hist_n;
         fill_cnt <= fill_n;
         match    <= hit_c;
         armed    <= (state_n == ARMED);
         if (cfg_load) begin
            pattern <= cfg_pattern;
            overlap <= cfg_overlap;
         end
      end
   end

   sat_counter #(
      .W (CNT_W)
   ) u_match_cnt (
      .clk (clk),
      .rst (rst),
      .inc (hit_c),
      .clr (clear_cnt),
      .cnt (match_cnt)
   );

endmodule
